// File: rtl/ahb_arb_ctrl.sv
// AHB bus arbiter: registered one-hot grant, owner index and lock indication,
// with internal beat tracking so handover happens only at legal burst points.
module ahb_arb_ctrl #(
  parameter int unsigned NUM_MST    = 4,
  parameter int unsigned MW         = 2,
  parameter int unsigned DEF_MASTER = 0,
  parameter int unsigned RR_EN      = 1,
  parameter int unsigned INCR_BEATS = 4
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic               hmastlock
);

  localparam int unsigned BW = 5;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [BW-1:0]      r_beats;
  logic [NUM_MST-1:0] r_hgrant;
  logic [MW-1:0]      r_gidx;
  logic [MW-1:0]      r_hmaster;
  logic               r_mastlock;
  logic               r_pend;

  logic [BW-1:0]      w_len_m1;
  logic [BW-1:0]      w_beats_nxt;
  logic               w_xfer;
  logic               w_rs;
  logic               w_arb_pt;
  logic [MW-1:0]      w_win;
  logic               w_found;
  logic [MW:0]        w_sum;
  logic [MW-1:0]      w_idx;

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_mastlock;

  // Burst length minus one for the owner's current burst type
  always_comb begin
    w_len_m1 = '0;
    case (hburst)
      3'b000:         w_len_m1 = '0;
      3'b001:         w_len_m1 = BW'(INCR_BEATS - 1);
      3'b010, 3'b011: w_len_m1 = BW'(3);
      3'b100, 3'b101: w_len_m1 = BW'(7);
      default:        w_len_m1 = BW'(15);
    endcase
  end

  // Next beat count and arbitration-point detection for an hready=1 edge
  always_comb begin
    w_xfer      = htrans[1];
    w_rs        = hresp[1];
    w_beats_nxt = r_beats;
    if (w_rs) begin
      w_beats_nxt = '0;
    end else if (htrans == TR_NONSEQ) begin
      w_beats_nxt = w_len_m1;
    end else if (htrans == TR_SEQ) begin
      w_beats_nxt = (r_beats != '0) ? (r_beats - BW'(1)) : '0;
    end
    // A locked owner keeps the bus unless the slave retries or splits it
    w_arb_pt = ((htrans == TR_IDLE) || (w_xfer && (w_beats_nxt <= BW'(1))) || w_rs)
               && !(hlock[r_hmaster] && !w_rs);
  end

  // Winner selection: round-robin from owner+1 or fixed lowest index
  always_comb begin
    w_win   = MW'(DEF_MASTER);
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    if (RR_EN != 0) begin
      for (int i = 1; i <= int'(NUM_MST); i++) begin
        w_sum = {1'b0, r_hmaster} + (MW+1)'(i);
        if (w_sum >= (MW+1)'(NUM_MST)) begin
          w_sum = w_sum - (MW+1)'(NUM_MST);
        end
        w_idx = w_sum[MW-1:0];
        if (!w_found && hbusreq[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(NUM_MST); i++) begin
        w_idx = MW'(i);
        if (!w_found && hbusreq[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  // Grant, ownership, lock and beat tracking; everything advances only on hready
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_hgrant   <= NUM_MST'(1) << DEF_MASTER;
      r_gidx     <= MW'(DEF_MASTER);
      r_hmaster  <= MW'(DEF_MASTER);
      r_mastlock <= 1'b0;
      r_beats    <= '0;
      r_pend     <= 1'b0;
    end else if (hready) begin
      r_beats <= w_beats_nxt;
      if (r_pend) begin
        // Grant changed last cycle: hand over the address bus, no re-arbitration
        r_hmaster  <= r_gidx;
        r_mastlock <= hlock[r_gidx];
        r_pend     <= 1'b0;
      end else begin
        r_mastlock <= hlock[r_hmaster];
        if (w_arb_pt && (w_win != r_gidx)) begin
          r_gidx   <= w_win;
          r_hgrant <= NUM_MST'(1) << w_win;
          r_pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb_ctrl.sv
// Scoreboard bench for ahb_arb_ctrl: directed cycles push expected outputs,
// a monitor pops and compares one entry per clock.
module tb_ahb_arb_ctrl;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] RETRY  = 2'b10;

  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = SINGLE;
  logic       hready = 1'b1;
  logic [1:0] hresp = OKAY;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  ahb_arb_ctrl #(
    .NUM_MST(4), .MW(2), .DEF_MASTER(0), .RR_EN(1), .INCR_BEATS(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                      input logic el, input string nm);
    exp_t e;
    @(posedge hclk);
    #2;
    hreset  = rst;
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    e.g = eg; e.m = em; e.l = el; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per clock, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (hgrant !== e.g || hmaster !== e.m || hmastlock !== e.l) begin
          errors++;
          $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmastlock=%b",
                   e.nm, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
        end
        checks++;
        if (!$onehot(hgrant)) begin
          errors++;
          $display("FAIL onehot_%s: got hgrant=%b, want one-hot", e.nm, hgrant);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    // T1 reset
    step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "t1_rst_a");
    step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "t1_rst_b");
    // T2 M1 gets the bus, runs INCR4 while M2 requests
    step(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0010, 2'd0, 0, "t2_grant_m1");
    step(0, 4'b0010, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0010, 2'd1, 0, "t2_own_m1");
    step(0, 4'b0110, 4'b0000, NONSEQ, INCR4,  1, OKAY, 4'b0010, 2'd1, 0, "t2_beat1");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, OKAY, 4'b0010, 2'd1, 0, "t2_beat2");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, OKAY, 4'b0100, 2'd1, 0, "t2_beat3_grant");
    step(0, 4'b0110, 4'b0000, SEQ,    INCR4,  1, OKAY, 4'b0100, 2'd2, 0, "t2_beat4_own");
    step(0, 4'b0100, 4'b0000, NONSEQ, SINGLE, 1, OKAY, 4'b0100, 2'd2, 0, "t2_regrant_m2");
    // T3 round-robin after a fresh reset
    step(1, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "t3_rst");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, OKAY, 4'b0010, 2'd0, 0, "t3_g1");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0010, 2'd1, 0, "t3_m1");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, OKAY, 4'b0100, 2'd1, 0, "t3_g2");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0100, 2'd2, 0, "t3_m2");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, OKAY, 4'b1000, 2'd2, 0, "t3_g3");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b1000, 2'd3, 0, "t3_m3");
    step(0, 4'b1111, 4'b0000, NONSEQ, SINGLE, 1, OKAY, 4'b0001, 2'd3, 0, "t3_g0");
    step(0, 4'b1111, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "t3_m0");
    // T4 M3 locked across two INCR8 bursts while M0 requests
    step(0, 4'b1000, 4'b1000, IDLE,   SINGLE, 1, OKAY, 4'b1000, 2'd0, 0, "t4_grant_m3");
    step(0, 4'b1000, 4'b1000, IDLE,   SINGLE, 1, OKAY, 4'b1000, 2'd3, 1, "t4_own_m3");
    step(0, 4'b1001, 4'b1000, NONSEQ, INCR8,  1, OKAY, 4'b1000, 2'd3, 1, "t4_b1_nonseq");
    for (int i = 0; i < 7; i++)
      step(0, 4'b1001, 4'b1000, SEQ, INCR8, 1, OKAY, 4'b1000, 2'd3, 1, "t4_b1_seq");
    step(0, 4'b1001, 4'b1000, NONSEQ, INCR8,  1, OKAY, 4'b1000, 2'd3, 1, "t4_b2_nonseq");
    step(0, 4'b1001, 4'b1000, IDLE,   INCR8,  1, OKAY, 4'b1000, 2'd3, 1, "t4_idle_locked");
    step(0, 4'b1001, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0001, 2'd3, 0, "t4_unlock_grant");
    step(0, 4'b1001, 4'b0000, IDLE,   SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "t4_own_m0");
    // T5 RETRY on beat 2 of M2's INCR8
    step(0, 4'b0100, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 2'd0, 0, "t5_grant_m2");
    step(0, 4'b0100, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0100, 2'd2, 0, "t5_own_m2");
    step(0, 4'b0101, 4'b0000, NONSEQ, INCR8,  1, OKAY,  4'b0100, 2'd2, 0, "t5_beat1");
    step(0, 4'b0101, 4'b0000, SEQ,    INCR8,  1, OKAY,  4'b0100, 2'd2, 0, "t5_beat2");
    step(0, 4'b0101, 4'b0000, SEQ,    INCR8,  0, RETRY, 4'b0100, 2'd2, 0, "t5_retry1");
    step(0, 4'b0101, 4'b0000, IDLE,   INCR8,  1, RETRY, 4'b0001, 2'd2, 0, "t5_retry2_grant");
    step(0, 4'b0101, 4'b0000, IDLE,   SINGLE, 1, OKAY,  4'b0001, 2'd0, 0, "t5_own_m0");
    // T6 wait states between grant and ownership
    step(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0010, 2'd0, 0, "t6_grant_m1");
    step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 0, OKAY, 4'b0010, 2'd0, 0, "t6_wait1");
    step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 0, OKAY, 4'b0010, 2'd0, 0, "t6_wait2");
    step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 0, OKAY, 4'b0010, 2'd0, 0, "t6_wait3");
    step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0010, 2'd1, 0, "t6_own_m1");
    step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0100, 2'd1, 0, "t6_grant_m2");
    step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0100, 2'd2, 0, "t6_own_m2");
    // No requests falls back to the default master
    step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd2, 0, "def_grant");
    step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "def_own");
    // hmastlock follows the unchanged owner's hlock
    step(0, 4'b0000, 4'b0001, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd0, 1, "lock_follow_on");
    step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, OKAY, 4'b0001, 2'd0, 0, "lock_follow_off");

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge hclk);
      wait_cyc++;
    end
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
